// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode definitions: opcode constants, format codes and the
// decoded-entry record carried through the decode pipe.
package rv_decode_pkg;

   localparam int XLEN_MAX = 64;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

   // pc/imm are sized for the widest core; narrower cores use the low XLEN bits.
   typedef struct packed {
      logic [31:0]         instr;
      logic [XLEN_MAX-1:0] pc;
      logic [XLEN_MAX-1:0] imm;
      fmt_t                fmt;
      logic                illegal;
   } dec_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RISC-V format classifier and immediate generator.
module imm_decode_comb
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]            instr,
   output logic signed [XLEN-1:0] imm,
   output fmt_t                   fmt,
   output logic                   illegal
);

   localparam bit RV64 = (XLEN == 64);

   function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
      return XLEN'(v);
   endfunction

   function automatic logic signed [XLEN-1:0] zext_shamt(input logic [5:0] v);
      return $signed(XLEN'(v));
   endfunction

   logic [6:0] opc;
   logic [2:0] funct3;
   logic       is_shift;

   always_comb begin
      opc      = instr[6:0];
      funct3   = instr[14:12];
      is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
      imm      = '0;
      fmt      = FMT_R;
      illegal  = 1'b0;
      case (opc)
         OPC_OP:   fmt = FMT_R;
         OPC_OP32: illegal = !RV64;
         OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
            fmt = FMT_I;
            imm = sext32({{20{instr[31]}}, instr[31:20]});
         end
         // Shift amounts are zero-extended so funct7/funct6 never reach imm.
         OPC_OPIMM: begin
            fmt = FMT_I;
            if (is_shift)
               imm = zext_shamt(RV64 ? instr[25:20] : {1'b0, instr[24:20]});
            else
               imm = sext32({{20{instr[31]}}, instr[31:20]});
         end
         OPC_OPIMM32: begin
            if (RV64) begin
               fmt = FMT_I;
               if (is_shift)
                  imm = zext_shamt({1'b0, instr[24:20]});
               else
                  imm = sext32({{20{instr[31]}}, instr[31:20]});
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = sext32({{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0});
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = sext32({instr[31:12], 12'b0});
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = sext32({{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0});
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered decode stage: immediate/format decode behind a valid/ready
// handshake with a 2-entry skid buffer (main = oldest, skid = newer).
module imm_decode_stage
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic signed [XLEN-1:0] dec_imm_p0;
   fmt_t                   dec_fmt_p0;
   logic                   dec_ill_p0;
   dec_entry_t             new_p0;
   dec_entry_t             main_p1;
   dec_entry_t             skid_p1;
   logic [1:0]             state_q;
   logic [1:0]             state_d;
   logic                   vld_p1;
   logic                   rdy_q;
   logic                   acc;
   logic                   take;
   logic                   load_main_new;
   logic                   load_main_skid;
   logic                   load_skid;

   imm_decode_comb #(.XLEN(XLEN)) u_dec (
      .instr   (in_instr),
      .imm     (dec_imm_p0),
      .fmt     (dec_fmt_p0),
      .illegal (dec_ill_p0)
   );

   // Stage p0 -> p1: decoded input entry, widened to the shared record.
   always_comb begin
      new_p0.instr   = in_instr;
      new_p0.pc      = XLEN_MAX'(in_pc);
      new_p0.imm     = XLEN_MAX'(dec_imm_p0);
      new_p0.fmt     = dec_fmt_p0;
      new_p0.illegal = dec_ill_p0;
   end

   assign acc  = in_valid && rdy_q;
   assign take = vld_p1 && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (acc) begin
               state_d       = ST_ONE;
               load_main_new = 1'b1;
            end
            ST_ONE: begin
               if (acc && !take) begin
                  state_d   = ST_TWO;
                  load_skid = 1'b1;
               end else if (acc && take) begin
                  load_main_new = 1'b1;
               end else if (take) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: if (take) begin
               state_d        = ST_ONE;
               load_main_skid = 1'b1;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Handshake flags are registered from the next state so neither ready
   // nor valid has a combinational path through this stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         vld_p1  <= 1'b0;
         rdy_q   <= 1'b1;
         main_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= (state_d != ST_EMPTY);
         rdy_q   <= (state_d != ST_TWO);
         if (load_main_new)
            main_p1 <= new_p0;
         else if (load_main_skid)
            main_p1 <= skid_p1;
         if (load_skid)
            skid_p1 <= new_p0;
      end
   end

   assign in_ready    = rdy_q;
   assign out_valid   = vld_p1;
   assign out_instr   = main_p1.instr;
   assign out_pc      = main_p1.pc[XLEN-1:0];
   assign out_imm     = main_p1.imm[XLEN-1:0];
   assign out_fmt     = main_p1.fmt;
   assign out_illegal = main_p1.illegal;

   generate
      if (XLEN < XLEN_MAX) begin : g_hi_unused
         logic unused_hi;
         assign unused_hi = ^{main_p1.pc[XLEN_MAX-1:XLEN], main_p1.imm[XLEN_MAX-1:XLEN]};
      end
   endgenerate

endmodule
